// File: rtl/iiitb_freqmeas_pkg.sv
// Shared state encoding, default sizing and count saturation for the
// iiitb_freqmeas divided-clock monitor.
package iiitb_freqmeas_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  localparam int DEF_W           = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOCK_CNT    = 4;
  localparam int DEF_TIMEOUT     = 31;

  // Clamp a count to the largest value representable in w bits.
  function automatic int sat_to_w(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/iiitb_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level plus a registered
// rising-edge strobe; q and rise both describe the same delayed sample.
module iiitb_sync_edge
  import iiitb_freqmeas_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES  // at least 2
) (
  input  logic clkin,
  input  logic rstn,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_d_p1;
  logic                   rise_p1;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      sync_p0 <= '0;
      s_d_p1  <= 1'b0;
      rise_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
      // edge stage: history flop and strobe register update together
      s_d_p1  <= sync_p0[SYNC_STAGES-1];
      rise_p1 <= sync_p0[SYNC_STAGES-1] & ~s_d_p1;
    end
  end

  assign q    = s_d_p1;
  assign rise = rise_p1;

endmodule

// File: rtl/iiitb_freqmeas.sv
// Measures period and high-time of a divided clock in clkin cycles, checks the
// period against an expected ratio, tracks lock and flags a stuck input.
module iiitb_freqmeas
  import iiitb_freqmeas_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic         clkin,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] n,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_cnt,
  output logic         meas_valid,
  output logic         match,
  output logic         locked,
  output logic         stuck
);

  localparam int         MCW = $clog2(LOCK_CNT + 1);
  localparam logic [W:0] TMO = (W+1)'(TIMEOUT);
  localparam logic [W:0] ONE = (W+1)'(1);

  state_t         state, state_nxt;
  logic [W:0]     cnt, hcnt;
  logic [MCW-1:0] match_cnt;
  logic           s, rise, timeout, hit;

  iiitb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clkin (clkin),
    .rstn  (rstn),
    .d     (sig_in),
    .q     (s),
    .rise  (rise)
  );

  assign timeout = (cnt == TMO);
  assign hit     = (cnt == {1'b0, n}) && (n >= W'(2));

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // disable wins over an edge, and an edge wins over the timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:              if (en) state_nxt = WAIT_EDGE;
      WAIT_EDGE, MEASURE: begin
        if (!en)          state_nxt = IDLE;
        else if (rise)    state_nxt = MEASURE;
        else if (timeout) state_nxt = WAIT_EDGE;
      end
      default:           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      hcnt       <= '0;
      match_cnt  <= '0;
      period     <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
      match      <= 1'b0;
      locked     <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (state == IDLE) begin
        cnt       <= '0;
        hcnt      <= '0;
        match_cnt <= '0;
      end else if (!en) begin
        cnt       <= '0;
        hcnt      <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
        stuck     <= 1'b0;
        match     <= 1'b0;
      end else if (rise) begin
        cnt   <= ONE;
        hcnt  <= ONE;
        stuck <= 1'b0;
        // the first edge after WAIT_EDGE only opens a window
        if (state == MEASURE) begin
          period     <= W'(sat_to_w(int'(cnt), W));
          high_cnt   <= W'(sat_to_w(int'(hcnt), W));
          meas_valid <= 1'b1;
          match      <= hit;
          if (!hit) begin
            match_cnt <= '0;
            locked    <= 1'b0;
          end else if (int'(match_cnt) + 1 >= LOCK_CNT) begin
            match_cnt <= MCW'(LOCK_CNT);
            locked    <= 1'b1;
          end else begin
            match_cnt <= match_cnt + MCW'(1);
          end
        end
      end else if (timeout) begin
        stuck     <= 1'b1;
        locked    <= 1'b0;
        match_cnt <= '0;
      end else begin
        cnt  <= cnt + ONE;
        hcnt <= hcnt + {{W{1'b0}}, s};
      end
    end
  end

endmodule

// File: tb/tb_iiitb_freqmeas.sv
// Bench for iiitb_freqmeas: directed waveforms plus random segments, checked
// every cycle against an edge-timestamp model of the measurement rules.
module tb_iiitb_freqmeas;

  localparam int W        = 4;
  localparam int SYNC     = 2;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 31;
  localparam int MAXV     = (1 << W) - 1;

  logic         clkin = 1'b0;
  logic         rstn  = 1'b0;
  logic         en    = 1'b0;
  logic [W-1:0] n     = 4'd4;
  logic         sig_in;
  logic [W-1:0] period, high_cnt;
  logic         meas_valid, match, locked, stuck;

  int checks = 0;
  int errors = 0;

  // waveform generator settings: 0 square wave gp/gh, 1 constant glev, 2 random bits
  int   gmode = 1;
  int   gp    = 4;
  int   gh    = 2;
  logic glev  = 1'b0;

  iiitb_freqmeas #(
    .W(W), .SYNC_STAGES(SYNC), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clkin      (clkin),
    .rstn       (rstn),
    .en         (en),
    .n          (n),
    .sig_in     (sig_in),
    .period     (period),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .match      (match),
    .locked     (locked),
    .stuck      (stuck)
  );

  always #5 clkin = ~clkin;

  initial begin : drive
    int ph;
    ph = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clkin);
      case (gmode)
        0:       sig_in = ((ph % gp) < gh);
        1:       sig_in = glev;
        default: sig_in = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  end

  // Reference model: the monitor sees sig_in SYNC+1 cycles late; a period is
  // the number of cycles between consecutive seen rising edges, high time is
  // the number of high samples inside that window.
  int           cyc = 0;
  int           mode = 0;   // 0 idle, 1 waiting for first edge, 2 measuring
  int           t_ref = 0;  // cycle at which the elapsed count was zero
  int           mcnt = 0;
  int           per, hi;
  bit           h0, h1, h2, h3;
  bit           m_qv, m_rise;
  int           win[$];
  logic [W-1:0] e_period = '0, e_high = '0;
  bit           e_mv = 0, e_match = 0, e_locked = 0, e_stuck = 0;

  initial begin : model
    forever begin
      @(posedge clkin or negedge rstn);
      if (!rstn) begin
        mode = 0; t_ref = 0; mcnt = 0; cyc = 0;
        {h3, h2, h1, h0} = 4'b0;
        win.delete();
        e_period = '0; e_high = '0;
        e_mv = 0; e_match = 0; e_locked = 0; e_stuck = 0;
      end else begin
        cyc++;
        m_qv   = h2;
        m_rise = h2 & ~h3;
        {h3, h2, h1, h0} = {h2, h1, h0, sig_in};
        e_mv = 0;
        if (mode == 0) begin
          if (en) begin mode = 1; t_ref = cyc; end
        end else if (!en) begin
          mode = 0; e_locked = 0; e_stuck = 0; e_match = 0; mcnt = 0;
        end else if (m_rise) begin
          e_stuck = 0;
          if (mode == 2) begin
            per = win.size();
            hi  = int'(win.sum());
            e_period = 4'((per > MAXV) ? MAXV : per);
            e_high   = 4'((hi > MAXV) ? MAXV : hi);
            e_mv     = 1;
            e_match  = (per == int'(n)) && (int'(n) >= 2);
            if (e_match) begin
              mcnt = (mcnt + 1 > LOCK_CNT) ? LOCK_CNT : mcnt + 1;
              e_locked = (mcnt == LOCK_CNT);
            end else begin
              mcnt = 0; e_locked = 0;
            end
          end
          mode  = 2;
          t_ref = cyc - 1;
          win   = '{1};
        end else if (cyc - 1 - t_ref >= TIMEOUT) begin
          e_stuck = 1; e_locked = 0; mcnt = 0; mode = 1;
        end else if (mode == 2) begin
          win.push_back(int'(m_qv));
        end
      end
    end
  end

  task automatic step();
    @(negedge clkin);
    checks++;
    if (period !== e_period || high_cnt !== e_high || meas_valid !== e_mv ||
        match !== e_match || locked !== e_locked || stuck !== e_stuck) begin
      errors++;
      $display("FAIL model t=%0t got p=%0d h=%0d v=%b m=%b l=%b s=%b required p=%0d h=%0d v=%b m=%b l=%b s=%b",
               $time, period, high_cnt, meas_valid, match, locked, stuck,
               e_period, e_high, e_mv, e_match, e_locked, e_stuck);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wait_mv(input int limit, output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while (meas_valid !== 1'b1 && steps < limit);
    if (meas_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_mv: no meas_valid within %0d cycles", limit);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int st, nmv;
    repeat (3) step();
    chk("rst_period", int'(period), 0);
    chk("rst_high", int'(high_cnt), 0);
    chk("rst_flags", int'({meas_valid, match, locked, stuck}), 0);
    rstn = 1'b1;

    // ideal divide-by-4
    gmode = 0; gp = 4; gh = 2; n = 4'd4; en = 1'b1;
    wait_mv(40, st);
    chk("d4_period", int'(period), 4);
    chk("d4_high", int'(high_cnt), 2);
    chk("d4_match", int'(match), 1);
    for (int i = 2; i <= 4; i++) begin
      wait_mv(10, st);
      if (i == 3) chk("d4_unlocked_3rd", int'(locked), 0);
    end
    chk("d4_locked_4th", int'(locked), 1);

    // divide-by-5, 3 high / 2 low
    gp = 5; gh = 3; n = 4'd5;
    repeat (4) wait_mv(20, st);
    chk("d5_period", int'(period), 5);
    chk("d5_high", int'(high_cnt), 3);
    chk("d5_match", int'(match), 1);
    nmv = 0;
    while (locked !== 1'b1 && nmv < 6) begin wait_mv(20, st); nmv++; end
    chk("d5_locked", int'(locked), 1);
    n = 4'd6;
    wait_mv(20, st);
    chk("d5_n6_match", int'(match), 0);
    chk("d5_n6_unlock", int'(locked), 0);
    chk("d5_n6_period", int'(period), 5);

    // input stuck high
    gmode = 1; glev = 1'b1; en = 1'b0;
    repeat (12) step();
    chk("stuck_idle", int'(stuck), 0);
    en = 1'b1; nmv = 0;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (meas_valid) nmv++;
    end
    chk("stuck_before_timeout", int'(stuck), 0);
    step();
    chk("stuck_after_timeout", int'(stuck), 1);
    gmode = 0; gp = 4; gh = 2;
    st = 0;
    do begin
      step(); st++;
      if (meas_valid) nmv++;
    end while (stuck === 1'b1 && st < 20);
    chk("stuck_cleared", int'(stuck), 0);
    chk("stuck_no_mv", nmv, 0);

    // divide-by-20 saturates a 4-bit period
    gp = 20; gh = 10; n = 4'd4;
    repeat (3) wait_mv(40, st);
    chk("d20_period", int'(period), 15);
    chk("d20_high", int'(high_cnt), 10);
    chk("d20_match", int'(match), 0);
    chk("d20_locked", int'(locked), 0);

    // disable coincident with a detected edge
    gp = 4; gh = 2; n = 4'd4;
    nmv = 0;
    do begin wait_mv(20, st); nmv++; end while (locked !== 1'b1 && nmv < 10);
    chk("relock", int'(locked), 1);
    repeat (3) step();
    en = 1'b0;
    step();
    chk("en_off_no_mv", int'(meas_valid), 0);
    chk("en_off_unlock", int'(locked), 0);
    chk("en_off_period_held", int'(period), 4);

    // asynchronous reset in the middle of a measurement
    en = 1'b1;
    wait_mv(40, st);
    step(); step();
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_period", int'(period), 0);
    chk("async_rst_high", int'(high_cnt), 0);
    chk("async_rst_flags", int'({meas_valid, match, locked, stuck}), 0);
    repeat (2) step();
    rstn = 1'b1;
    wait_mv(40, st);
    chk("post_rst_discard", int'(st >= 8), 1);
    chk("post_rst_period", int'(period), 4);
    chk("post_rst_high", int'(high_cnt), 2);

    // randomized segments
    for (int seg = 0; seg < 10; seg++) begin
      gp = $urandom_range(2, 14);
      gh = $urandom_range(1, gp - 1);
      gmode = (seg % 4 == 3) ? 2 : 0;
      n = (seg % 2 == 0) ? 4'(gp) : 4'($urandom_range(0, 15));
      for (int c = 0; c < 60; c++) begin
        en = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
        if ($urandom_range(0, 99) < 3) n = 4'($urandom_range(0, 15));
        step();
      end
    end
    gmode = 1; glev = 1'($urandom_range(0, 1)); en = 1'b1;
    repeat (45) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
